// File: rtl/pll_reset_supervisor.sv
// Supervises PLL lock from the free-running reference clock. It pulses the PLL reset, qualifies lock,
// releases staggered downstream resets, and counts timeouts and losses of lock.
module pll_reset_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE    = 1000,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int NUM_RESETS     = 4,
  parameter int RST_STAGGER    = 8
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  clr_counts,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] rst_out_n,
  output logic                  sys_ready,
  output logic                  timeout_err,
  output logic [7:0]            lock_loss_cnt,
  output logic [7:0]            retry_cnt
);

  localparam int REL_LAST = (NUM_RESETS - 1) * RST_STAGGER;
  localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX  = (MAX_AB > REL_LAST) ? MAX_AB : REL_LAST;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [TMO_W-1:0]        tmo;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    lk;
  logic                    tmo_hit;
  logic                    loss_evt;
  logic [NUM_RESETS-1:0]   release_hit;

  // pll_locked is asynchronous to refclk; only the last stage is ever looked at
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk = sync[SYNC_STAGES-1];

  always_comb begin
    tmo_hit  = 1'b0;
    loss_evt = 1'b0;
    if ((state == S_WAIT_LOCK) || (state == S_STABLE)) begin
      tmo_hit = (tmo == TMO_W'(LOCK_TIMEOUT - 1));
    end
    if ((state == S_RELEASE) || (state == S_RUN)) begin
      loss_evt = !lk;
    end
  end

  // Bit i of the release mask fires when the RELEASE counter reaches its staggered slot
  generate
    for (genvar gi = 0; gi < NUM_RESETS; gi++) begin : g_release
      assign release_hit[gi] = (cnt == CNT_W'(gi * RST_STAGGER));
    end
  endgenerate

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      tmo         <= '0;
      pll_rst     <= 1'b1;
      rst_out_n   <= '0;
      sys_ready   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_PLL_RST: begin
          pll_rst   <= 1'b1;
          rst_out_n <= '0;
          sys_ready <= 1'b0;
          if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            tmo     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (tmo_hit) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
            if (lk) begin
              state <= S_STABLE;
              cnt   <= '0;
            end
          end
        end

        // The timeout keeps running across STABLE<->WAIT_LOCK bounces so a chattering lock still retries
        S_STABLE: begin
          if (tmo_hit) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
            if (!lk) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
              state <= S_RELEASE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_RELEASE: begin
          if (!lk) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            rst_out_n <= '0;
            sys_ready <= 1'b0;
          end else begin
            rst_out_n <= rst_out_n | release_hit;
            if (cnt == CNT_W'(REL_LAST)) begin
              state     <= S_RUN;
              cnt       <= '0;
              sys_ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (!lk) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            rst_out_n <= '0;
            sys_ready <= 1'b0;
          end
        end

        default: begin
          state     <= S_PLL_RST;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          rst_out_n <= '0;
          sys_ready <= 1'b0;
        end
      endcase
    end
  end

  // Event counters saturate; a clear coinciding with an increment leaves zero
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else if (clr_counts) begin
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      if (loss_evt && (lock_loss_cnt != 8'hFF)) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
      if (tmo_hit && (retry_cnt != 8'hFF)) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor with shortened timing parameters.
module tb_pll_reset_supervisor;

  localparam int NR = 4;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          clr_counts = 1'b0;
  logic          pll_rst;
  logic [NR-1:0] rst_out_n;
  logic          sys_ready;
  logic          timeout_err;
  logic [7:0]    lock_loss_cnt;
  logic [7:0]    retry_cnt;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  always #5 refclk = ~refclk;

  pll_reset_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE   (20),
    .LOCK_TIMEOUT  (200),
    .NUM_RESETS    (NR),
    .RST_STAGGER   (3)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .clr_counts   (clr_counts),
    .pll_rst      (pll_rst),
    .rst_out_n    (rst_out_n),
    .sys_ready    (sys_ready),
    .timeout_err  (timeout_err),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt)
  );

  typedef struct {
    int            cyc;
    logic          lock_in;
    logic          exp_pll_rst;
    logic [NR-1:0] exp_rst;
    logic          exp_ready;
    logic [7:0]    exp_loss;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur, act, exp);
    end else begin
      $display("ok   %s cycle %0d: %0h", name, cur, act);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cur++;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    clr_counts = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    cur   = 0;
  endtask

  task automatic wait_bit0(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (rst_out_n[0]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_pll_rst(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (pll_rst) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  int   first_to;
  int   pulses;
  logic pr207;
  logic pr208;
  bit   ok_a;
  bit   ok_b;

  initial begin
    // cycle, lock applied after check, pll_rst, rst_out_n, sys_ready, lock_loss_cnt
    vecs[0]  = '{0,  1'b1, 1'b1, 4'b0000, 1'b0, 8'd0};
    vecs[1]  = '{3,  1'b1, 1'b1, 4'b0000, 1'b0, 8'd0};
    vecs[2]  = '{4,  1'b1, 1'b0, 4'b0000, 1'b0, 8'd0};
    vecs[3]  = '{25, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0};
    vecs[4]  = '{26, 1'b1, 1'b0, 4'b0001, 1'b0, 8'd0};
    vecs[5]  = '{28, 1'b1, 1'b0, 4'b0001, 1'b0, 8'd0};
    vecs[6]  = '{29, 1'b1, 1'b0, 4'b0011, 1'b0, 8'd0};
    vecs[7]  = '{32, 1'b1, 1'b0, 4'b0111, 1'b0, 8'd0};
    vecs[8]  = '{34, 1'b1, 1'b0, 4'b0111, 1'b0, 8'd0};
    vecs[9]  = '{35, 1'b1, 1'b0, 4'b1111, 1'b1, 8'd0};
    vecs[10] = '{40, 1'b0, 1'b0, 4'b1111, 1'b1, 8'd0};
    vecs[11] = '{41, 1'b1, 1'b0, 4'b1111, 1'b1, 8'd0};
    vecs[12] = '{42, 1'b1, 1'b0, 4'b1111, 1'b1, 8'd0};
    vecs[13] = '{43, 1'b1, 1'b1, 4'b0000, 1'b0, 8'd1};
    vecs[14] = '{46, 1'b1, 1'b1, 4'b0000, 1'b0, 8'd1};
    vecs[15] = '{47, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd1};
    vecs[16] = '{68, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd1};
    vecs[17] = '{69, 1'b1, 1'b0, 4'b0001, 1'b0, 8'd1};
    vecs[18] = '{75, 1'b1, 1'b0, 4'b0111, 1'b0, 8'd1};
    vecs[19] = '{78, 1'b1, 1'b0, 4'b1111, 1'b1, 8'd1};

    // Clean lock, staggered release, one-cycle drop in RUN and full re-sequence
    do_reset();
    for (int i = 0; i < 20; i++) begin
      while (cur < vecs[i].cyc) tick();
      chk("pll_rst", 32'(pll_rst), 32'(vecs[i].exp_pll_rst));
      chk("rst_out_n", 32'(rst_out_n), 32'(vecs[i].exp_rst));
      chk("sys_ready", 32'(sys_ready), 32'(vecs[i].exp_ready));
      chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(vecs[i].exp_loss));
      chk("timeout_err", 32'(timeout_err), 32'd0);
      pll_locked = vecs[i].lock_in;
    end
    chk("retry_cnt_run", 32'(retry_cnt), 32'd0);

    // Asynchronous reset in RUN
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_run_pll_rst", 32'(pll_rst), 32'd1);
    chk("async_run_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("async_run_sys_ready", 32'(sys_ready), 32'd0);
    chk("async_run_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    cur   = 0;

    // Asynchronous reset mid-STABLE, then restart from PLL_RST
    while (cur < 15) tick();
    chk("stable_pll_rst", 32'(pll_rst), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_stable_pll_rst", 32'(pll_rst), 32'd1);
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    cur   = 0;
    while (cur < 3) tick();
    chk("restart_pll_rst_c3", 32'(pll_rst), 32'd1);
    tick();
    chk("restart_pll_rst_c4", 32'(pll_rst), 32'd0);
    while (cur < 25) tick();
    chk("restart_rst_c25", 32'(rst_out_n), 32'd0);
    tick();
    chk("restart_rst_c26", 32'(rst_out_n), 32'b0001);

    // Loss of lock during RELEASE after bit 1 released
    while (cur < 29) tick();
    chk("rel_rst_c29", 32'(rst_out_n), 32'b0011);
    pll_locked = 1'b0;
    while (cur < 31) tick();
    chk("rel_rst_c31", 32'(rst_out_n), 32'b0011);
    chk("rel_loss_c31", 32'(lock_loss_cnt), 32'd0);
    tick();
    chk("rel_rst_c32", 32'(rst_out_n), 32'd0);
    chk("rel_loss_c32", 32'(lock_loss_cnt), 32'd1);
    chk("rel_pll_rst_c32", 32'(pll_rst), 32'd1);
    chk("rel_ready_c32", 32'(sys_ready), 32'd0);

    // Lock chattering faster than LOCK_STABLE -> one timeout and retry
    do_reset();
    first_to = -1;
    pulses   = 0;
    pr207    = 1'b0;
    pr208    = 1'b1;
    while (cur < 215) begin
      pll_locked = ((cur / 5) % 2) == 1;
      tick();
      if (timeout_err) begin
        pulses++;
        if (first_to < 0) first_to = cur;
      end
      if (cur == 207) pr207 = pll_rst;
      if (cur == 208) pr208 = pll_rst;
    end
    chk("timeout_cycle", 32'(first_to), 32'd204);
    chk("timeout_pulses", 32'(pulses), 32'd1);
    chk("retry_cnt", 32'(retry_cnt), 32'd1);
    chk("retry_pll_rst_c207", 32'(pr207), 32'd1);
    chk("retry_pll_rst_c208", 32'(pr208), 32'd0);
    chk("retry_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    chk("clr_retry_cnt", 32'(retry_cnt), 32'd0);

    // Saturate lock_loss_cnt with repeated losses during RELEASE
    do_reset();
    pll_locked = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      wait_bit0(ok_a);
      pll_locked = 1'b0;
      wait_pll_rst(ok_b);
      pll_locked = 1'b1;
      if (!ok_a || !ok_b) begin
        chk("sat_wait_bound", 32'({ok_a, ok_b}), 32'b11);
        break;
      end
      if (n == 254) chk("loss_cnt_254", 32'(lock_loss_cnt), 32'd254);
      if (n == 255) chk("loss_cnt_255", 32'(lock_loss_cnt), 32'd255);
      if (n == 260) chk("loss_cnt_260", 32'(lock_loss_cnt), 32'd255);
    end

    // clr_counts on the same edge as a loss of lock
    wait_bit0(ok_a);
    chk("clr_wait_bound", 32'(ok_a), 32'd1);
    pll_locked = 1'b0;
    tick();
    tick();
    chk("pre_clr_loss_cnt", 32'(lock_loss_cnt), 32'd255);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    chk("clr_loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("clr_loss_cnt", 32'(lock_loss_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
